reduce_gate_stream: RTL and testbench



---
 rtl/reduce_gate_stream.sv | 174 +++++++++++++++++
 tb/tb_reduce_gate_stream.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/reduce_gate_stream.sv
// Streaming N-bit AND/OR/XOR reducer: folds each beat to one bit, accumulates across a packet, returns one result per packet.
// Optional REDUCE_INV_EN adds an inv input that inverts the packet result (NAND/NOR/XNOR).
module reduce_gate_stream #(
    parameter int N         = 3,
    parameter int MAX_BEATS = 8,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    input  logic [1:0]    op,
`ifdef REDUCE_INV_EN
    input  logic          inv,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_data,
    output logic [CW-1:0] out_beats,
    output logic          out_trunc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Fold a whole word to one bit; code 11 aliases AND.
    function automatic logic reduce_word(input logic [1:0] op_f, input logic [N-1:0] d);
        logic r;
        case (op_f)
            2'b01:   r = |d;
            2'b10:   r = ^d;
            default: r = &d;
        endcase
        return r;
    endfunction

    function automatic logic combine(input logic [1:0] op_f, input logic a, input logic b);
        logic r;
        case (op_f)
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    state_t        state_r, state_s;
    logic          acc_r, acc_s;
    logic [1:0]    op_q_r, op_q_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          trunc_r, trunc_s;
    logic [1:0]    op_eff_s;
    logic          beat_s;
    logic [CW-1:0] cnt_inc_s;
    logic          cap_full_s;
`ifdef REDUCE_INV_EN
    logic          inv_q_r, inv_q_s;
`endif

    // Beat reduction: the operator is only taken from the port on the first beat.
    always_comb begin
        if (state_r == ST_IDLE) begin
            op_eff_s = op;
        end else begin
            op_eff_s = op_q_r;
        end
        beat_s     = reduce_word(op_eff_s, in_data);
        cnt_inc_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        cap_full_s = (cnt_inc_s == CW'(MAX_BEATS));
    end

    // Next-state and next-register values.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        op_q_s  = op_q_r;
        cnt_s   = cnt_r;
        trunc_s = trunc_r;
`ifdef REDUCE_INV_EN
        inv_q_s = inv_q_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_s  = beat_s;
                    op_q_s = op;
                    cnt_s  = {{(CW-1){1'b0}}, 1'b1};
`ifdef REDUCE_INV_EN
                    inv_q_s = inv;
`endif
                    // Reaching HOLD without in_last is only possible when MAX_BEATS is 1.
                    if (in_last || (MAX_BEATS == 1)) begin
                        state_s = ST_HOLD;
                        trunc_s = ~in_last;
                    end else begin
                        state_s = ST_ACCUM;
                        trunc_s = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_s = combine(op_q_r, acc_r, beat_s);
                    cnt_s = cnt_inc_s;
                    if (in_last || cap_full_s) begin
                        state_s = ST_HOLD;
                        trunc_s = ~in_last;
                    end else begin
                        state_s = ST_ACCUM;
                    end
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                    trunc_s = 1'b0;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                acc_s   = 1'b0;
                op_q_s  = 2'b00;
                cnt_s   = {CW{1'b0}};
                trunc_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            acc_r   <= 1'b0;
            op_q_r  <= 2'b00;
            cnt_r   <= {CW{1'b0}};
            trunc_r <= 1'b0;
`ifdef REDUCE_INV_EN
            inv_q_r <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            op_q_r  <= op_q_s;
            cnt_r   <= cnt_s;
            trunc_r <= trunc_s;
`ifdef REDUCE_INV_EN
            inv_q_r <= inv_q_s;
`endif
        end
    end

    assign in_ready  = (state_r != ST_HOLD);
    assign out_valid = (state_r == ST_HOLD);
    assign out_beats = cnt_r;
    assign out_trunc = trunc_r;
`ifdef REDUCE_INV_EN
    assign out_data  = acc_r ^ inv_q_r;
`else
    assign out_data  = acc_r;
`endif

endmodule

// File: tb/tb_reduce_gate_stream.sv
// Directed bench for reduce_gate_stream: an 8-beat instance and a 4-beat instance share one stimulus stream.
module tb_reduce_gate_stream;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_last;
    logic [1:0] op;
    logic       out_ready;
`ifdef REDUCE_INV_EN
    logic       inv;
`endif

    logic       a_in_ready, a_out_valid, a_out_data, a_out_trunc;
    logic [3:0] a_out_beats;
    logic       b_in_ready, b_out_valid, b_out_data, b_out_trunc;
    logic [2:0] b_out_beats;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reduce_gate_stream #(.N(3), .MAX_BEATS(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .in_last(in_last), .op(op),
`ifdef REDUCE_INV_EN
        .inv(inv),
`endif
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_beats(a_out_beats), .out_trunc(a_out_trunc)
    );

    reduce_gate_stream #(.N(3), .MAX_BEATS(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .in_last(in_last), .op(op),
`ifdef REDUCE_INV_EN
        .inv(inv),
`endif
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_beats(b_out_beats), .out_trunc(b_out_trunc)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic v, input logic d, input logic [3:0] b, input logic t);
        check({tag, ".a_valid"}, 8'(a_out_valid), 8'(v));
        check({tag, ".a_data"},  8'(a_out_data),  8'(d));
        check({tag, ".a_beats"}, 8'(a_out_beats), 8'(b));
        check({tag, ".a_trunc"}, 8'(a_out_trunc), 8'(t));
    endtask

    task automatic check_b(input string tag, input logic v, input logic d, input logic [2:0] b, input logic t);
        check({tag, ".b_valid"}, 8'(b_out_valid), 8'(v));
        check({tag, ".b_data"},  8'(b_out_data),  8'(d));
        check({tag, ".b_beats"}, 8'(b_out_beats), 8'(b));
        check({tag, ".b_trunc"}, 8'(b_out_trunc), 8'(t));
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 3'b000;
        in_last   = 1'b0;
        op        = 2'b00;
        out_ready = 1'b0;
`ifdef REDUCE_INV_EN
        inv       = 1'b0;
`endif
        #12;
        check_a("reset", 1'b0, 1'b0, 4'd0, 1'b0);
        check_b("reset", 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset.in_ready", 8'(a_in_ready), 8'd1);

        // Single-beat AND of 111.
        in_valid = 1'b1; in_data = 3'b111; in_last = 1'b1; op = 2'b00; out_ready = 1'b1;
        tick();
        check_a("and1", 1'b1, 1'b1, 4'd1, 1'b0);
        check("and1.in_ready", 8'(a_in_ready), 8'd0);
        in_valid = 1'b0;
        tick();
        check("and1.drop_valid", 8'(a_out_valid), 8'd0);
        check("and1.idle_ready", 8'(a_in_ready), 8'd1);

        // OR over 000,000,100.
        out_ready = 1'b0; in_valid = 1'b1; op = 2'b01; in_last = 1'b0; in_data = 3'b000;
        tick();
        tick();
        in_data = 3'b100; in_last = 1'b1;
        tick();
        check_a("or_hit", 1'b1, 1'b1, 4'd3, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // OR over 000,000,000.
        out_ready = 1'b0; in_valid = 1'b1; op = 2'b01; in_last = 1'b0; in_data = 3'b000;
        tick();
        tick();
        in_last = 1'b1;
        tick();
        check_a("or_miss", 1'b1, 1'b0, 4'd3, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // XOR latched on beat 1; op change on beat 2 is ignored.
        out_ready = 1'b0; in_valid = 1'b1; op = 2'b10; in_data = 3'b011; in_last = 1'b0;
        tick();
        op = 2'b00; in_data = 3'b001; in_last = 1'b1;
        tick();
        check_a("xor_kept", 1'b1, 1'b1, 4'd2, 1'b0);

        // Backpressure: a pending result blocks the next beat.
        in_data = 3'b111; op = 2'b00; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp.in_ready", 8'(a_in_ready), 8'd0);
            check_a("bp.hold", 1'b1, 1'b1, 4'd2, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        check("bp.release_valid", 8'(a_out_valid), 8'd0);
        check("bp.release_ready", 8'(a_in_ready), 8'd1);
        tick();
        check_a("bp.accepted", 1'b1, 1'b1, 4'd1, 1'b0);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset in ACCUM after two beats.
        reset_n = 1'b1; out_ready = 1'b0; in_valid = 1'b1; op = 2'b10; in_last = 1'b0; in_data = 3'b100;
        tick();
        in_data = 3'b000;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_a("mid_reset", 1'b0, 1'b0, 4'd0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_reset.in_ready", 8'(a_in_ready), 8'd1);
        in_valid = 1'b1; op = 2'b01; in_data = 3'b000; in_last = 1'b1; out_ready = 1'b1;
        tick();
        check_a("post_reset", 1'b1, 1'b0, 4'd1, 1'b0);
        in_valid = 1'b0;
        tick();

        // Forced close on the 4-beat instance.
        out_ready = 1'b0; in_valid = 1'b1; op = 2'b00; in_data = 3'b111; in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check_b("trunc", 1'b1, 1'b1, 3'd4, 1'b1);
        check("trunc.a_still_open", 8'(a_out_valid), 8'd0);
        in_last = 1'b1; out_ready = 1'b1;
        tick();
        check_a("a_five", 1'b1, 1'b1, 4'd5, 1'b0);
        check("trunc.b_released", 8'(b_out_valid), 8'd0);
        tick();
        check_b("trunc.next", 1'b1, 1'b1, 3'd1, 1'b0);
        in_valid = 1'b0;
        tick();

        // in_last on the capacity beat is a normal close.
        out_ready = 1'b0; in_valid = 1'b1; op = 2'b10; in_data = 3'b110; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        in_data = 3'b100; in_last = 1'b1;
        tick();
        check_b("last_at_cap", 1'b1, 1'b1, 3'd4, 1'b0);
        check_a("xor4", 1'b1, 1'b1, 4'd4, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

`ifdef REDUCE_INV_EN
        in_valid = 1'b1; op = 2'b00; inv = 1'b1; in_data = 3'b111; in_last = 1'b1;
        tick();
        check_a("nand", 1'b1, 1'b0, 4'd1, 1'b0);
        in_valid = 1'b0; inv = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
